mux_2_to_1: RTL and testbench
=============================

Name: mux_2_to_1

Overview:
- Registered 2:1 selector: each clock picks one of two equal-width data inputs and drives it on a registered output.
- Used as a small datapath steering element, e.g. choosing between two control/value sources ahead of downstream logic.
- Output latency is exactly one clock. A valid flag travels alongside the data.

Parameters:
- WIDTH, 1, bit width of in0, in1 and out; legal range 1..64.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset, sampled on rising clk edge.
- sel  input  1  select: 0 chooses in0, 1 chooses in1.
- in0  input  WIDTH  data source 0.
- in1  input  WIDTH  data source 1.
- in_valid  input  1  qualifies sel/in0/in1 this cycle.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  registered copy of in_valid; high means out holds a fresh selection.

Behaviour:
- One clock, clk; reset is synchronous and active-high (rst). No asynchronous paths, no clock gating.
- Reset: on a rising edge with rst=1, out <= 0 (all WIDTH bits) and out_valid <= 0. rst has priority over every other input.
- Normal operation (rst=0), every rising edge:
  - out_valid <= in_valid.
  - If in_valid=1: out <= (sel ? in1 : in0).
  - If in_valid=0: out holds its previous value; no update.
- Latency: exactly 1 cycle from sampled inputs to out/out_valid. Throughput: one selection per cycle; back-to-back valid cycles are allowed with no bubbles.
- sel is sampled only on edges where in_valid=1. When in_valid=0, sel/in0/in1 are don't-care.
- X handling: if sel is X/Z while in_valid=1, out is unspecified. The verification bench flags this with an assertion; RTL adds no special handling.
- Release from reset: the first edge with rst=0 behaves as normal operation. Before any valid sample, out stays 0.
- Reset mid-stream: a valid sample presented on the same edge as rst=1 is discarded; out=0 and out_valid=0 next cycle.
- No combinational path from any input to any output.

Decomposition:
- No shared package required; WIDTH is the only configurable constant.
- Optional single sub-module mux_2_to_1_sel: purely combinational select (sel, in0, in1 -> y). The top wraps it with the output/valid registers.
- No typedefs needed.

Test Plan:
- Reset: drive rst=1 for 2 cycles with in_valid=1, sel=1, in1=1 -> out=0, out_valid=0 throughout; after rst=0 with in_valid=0, out stays 0.
- Select in0: rst=0, in_valid=1, sel=0, in0=1, in1=0 -> next cycle out=1, out_valid=1.
- Select in1: sel=1, in0=0, in1=1 -> out=1; then sel=0, in0=0, in1=1 -> out=0; then sel=1, in0=1, in1=0 -> out=0. Each result appears one cycle after its inputs; check four consecutive cycles with no bubbles.
- Hold: after out=1, drop in_valid to 0 and toggle sel/in0/in1 randomly for 5 cycles -> out stays 1, out_valid=0.
- Mid-stream reset: valid stream sel=1, in1=1; assert rst for one edge -> that cycle's data is dropped, out=0, out_valid=0. Next valid sample sel=0, in0=1 -> out=1 one cycle later.
- WIDTH=8 build: in0=8'hA5, in1=8'h3C alternating sel 0/1 every cycle -> out alternates 8'hA5/8'h3C, lagging by one cycle; exhaustive 1-bit truth table at WIDTH=1.

Source files
------------

// File: rtl/mux_2_to_1_pkg.sv
// Shared definitions for the registered 2:1 selector.
// The select encoding is named so call sites read as intent rather than bare bits.
package mux_2_to_1_pkg;

    typedef enum logic {
        SEL_IN0 = 1'b0,
        SEL_IN1 = 1'b1
    } sel_e;

endpackage

// File: rtl/mux_2_to_1_sel.sv
// Purely combinational 2:1 select: y follows in1 when sel is SEL_IN1, else in0.
import mux_2_to_1_pkg::*;

module mux_2_to_1_sel #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = in0;
        if (sel_e'(sel) == SEL_IN1) begin
            y = in1;
        end
    end

endmodule

// File: rtl/mux_2_to_1.sv
// Registered 2:1 selector with a valid flag; one-cycle latency, full throughput.
// out only updates on valid samples; rst (synchronous) clears both registers.
import mux_2_to_1_pkg::*;

module mux_2_to_1 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             in_valid,
    output logic [WIDTH-1:0] out,
    output logic             out_valid
);

    logic [WIDTH-1:0] sel_y;
    logic [WIDTH-1:0] out_d;
    logic [WIDTH-1:0] out_q;
    logic             valid_d;
    logic             valid_q;

    mux_2_to_1_sel #(
        .WIDTH (WIDTH)
    ) u_sel (
        .sel (sel),
        .in0 (in0),
        .in1 (in1),
        .y   (sel_y)
    );

    // Invalid cycles leave the data register untouched; the flag always follows in_valid.
    always_comb begin
        out_d   = out_q;
        valid_d = in_valid;
        if (in_valid) begin
            out_d = sel_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out       = out_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_2_to_1.sv
// Bench for mux_2_to_1: WIDTH=8 and WIDTH=1 instances share stimulus; expected results
// are queued when inputs are driven and compared one edge later.
module tb_mux_2_to_1;

    typedef struct {
        logic       rst;
        logic       vld;
        logic       sel;
        logic [7:0] a;
        logic [7:0] b;
    } vec_t;

    typedef struct {
        logic [7:0] d8;
        logic       d1;
        logic       v;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel;
    logic       in_valid;
    logic [7:0] in0;
    logic [7:0] in1;
    logic [7:0] out8;
    logic       out8_valid;
    logic [0:0] out1;
    logic       out1_valid;

    int errors = 0;
    int checks = 0;

    exp_t       sb[$];
    logic [7:0] m8 = '0;
    logic       m1 = 1'b0;

    vec_t vecs[64];
    int   nv = 0;

    always #5 clk = ~clk;

    mux_2_to_1 #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .in0       (in0),
        .in1       (in1),
        .in_valid  (in_valid),
        .out       (out8),
        .out_valid (out8_valid)
    );

    mux_2_to_1 #(.WIDTH(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .in0       (in0[0]),
        .in1       (in1[0]),
        .in_valid  (in_valid),
        .out       (out1),
        .out_valid (out1_valid)
    );

    always @(posedge clk) begin
        if (rst === 1'b0 && in_valid === 1'b1) begin
            assert (!$isunknown(sel)) else $error("sel unknown while in_valid=1");
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic add(input logic r, input logic v, input logic s,
                       input logic [7:0] a, input logic [7:0] b);
        vecs[nv].rst = r;
        vecs[nv].vld = v;
        vecs[nv].sel = s;
        vecs[nv].a   = a;
        vecs[nv].b   = b;
        nv++;
    endtask

    task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic v, input logic s,
                        input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        rst      = r;
        in_valid = v;
        sel      = s;
        in0      = a;
        in1      = b;
        if (r) begin
            m8 = '0;
            m1 = 1'b0;
        end else if (v) begin
            m8 = s ? b : a;
            m1 = s ? b[0] : a[0];
        end
        e.d8 = m8;
        e.d1 = m1;
        e.v  = r ? 1'b0 : v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk8({tag, ".out8"},   out8,                 e.d8);
        chk8({tag, ".out1"},   {7'd0, out1[0]},      {7'd0, e.d1});
        chk8({tag, ".valid8"}, {7'd0, out8_valid},   {7'd0, e.v});
        chk8({tag, ".valid1"}, {7'd0, out1_valid},   {7'd0, e.v});
    endtask

    initial begin
        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in0 = '0; in1 = '0;

        // reset with a valid sample pending, then idle release
        add(1, 1, 1, 8'h00, 8'h01);
        add(1, 1, 1, 8'h00, 8'h01);
        add(0, 0, 0, 8'h00, 8'h00);
        // select in0, then back-to-back selections
        add(0, 1, 0, 8'h01, 8'h00);
        add(0, 1, 1, 8'h00, 8'h01);
        add(0, 1, 0, 8'h00, 8'h01);
        add(0, 1, 1, 8'h01, 8'h00);
        // alternating WIDTH=8 pattern
        for (int i = 0; i < 6; i++) add(0, 1, i[0], 8'hA5, 8'h3C);
        // 1-bit truth table
        for (int i = 0; i < 8; i++) add(0, 1, i[2], {7'd0, i[1]}, {7'd0, i[0]});

        for (int i = 0; i < nv; i++) begin
            step($sformatf("vec%0d", i), vecs[i].rst, vecs[i].vld, vecs[i].sel,
                 vecs[i].a, vecs[i].b);
        end

        // hold: load out=1, then invalid cycles with random junk
        step("hold_load", 0, 1, 1, 8'h00, 8'hFF);
        for (int i = 0; i < 5; i++) begin
            step($sformatf("hold%0d", i), 0, 0, 1'($urandom_range(0, 1)),
                 8'($urandom), 8'($urandom));
        end

        // mid-stream reset drops the coincident valid sample
        step("mid_pre",  0, 1, 1, 8'h00, 8'hFF);
        step("mid_rst",  1, 1, 1, 8'h00, 8'hFF);
        step("mid_post", 0, 1, 0, 8'h5B, 8'h00);
        step("mid_idle", 0, 0, 1, 8'h00, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
